// File: rtl/mult_div_unit.sv
// Iterative 32x32 multiply / 32/32 divide unit with HI/LO result registers.
// One radix-2 step per cycle; signed ops iterate on magnitudes and fix signs at the end.
module mult_div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] operand_1,
    input  logic [31:0] operand_2,
    input  logic        flush,
    output logic        stall_req,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    // state | meaning
    // IDLE  | waiting for start; hi/lo hold the last result
    // BUSY  | one shift-add / restoring-subtract step per cycle, cnt 0..31
    // DONE  | hi/lo just written, done pulses for this cycle only
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic        is_div;
    logic        neg_main;
    logic        neg_rem;
    logic [31:0] addend;
    logic [63:0] acc;

    logic        op_signed;
    logic        op_div;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        div_by_zero;

    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_rem;
    logic [32:0] div_diff;
    logic [63:0] div_next;
    logic [63:0] acc_next;

    logic [63:0] prod;
    logic [31:0] quot;
    logic [31:0] rem;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    assign op_signed   = ~op[0];
    assign op_div      = op[1];
    assign a_neg       = op_signed & operand_1[31];
    assign b_neg       = op_signed & operand_2[31];
    assign a_mag       = a_neg ? (~operand_1 + 32'd1) : operand_1;
    assign b_mag       = b_neg ? (~operand_2 + 32'd1) : operand_2;
    assign div_by_zero = op_div & (operand_2 == 32'd0);

    // Multiply: acc = {partial product, remaining multiplier bits}.
    assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, addend} : 33'd0);
    assign mul_next = {mul_sum, acc[31:1]};

    // Divide: acc = {remainder, dividend bits shifting into quotient}.
    // Remainder stays below the divisor, so a 33-bit trial subtract is enough.
    assign div_rem  = acc[63:31];
    assign div_diff = div_rem - {1'b0, addend};
    assign div_next = div_diff[32] ? {div_rem[31:0], acc[30:0], 1'b0}
                                   : {div_diff[31:0], acc[30:0], 1'b1};

    assign acc_next = is_div ? div_next : mul_next;

    assign prod = neg_main ? (~acc_next + 64'd1) : acc_next;
    assign quot = neg_main ? (~acc_next[31:0] + 32'd1) : acc_next[31:0];
    assign rem  = neg_rem  ? (~acc_next[63:32] + 32'd1) : acc_next[63:32];

    assign res_hi = is_div ? rem  : prod[63:32];
    assign res_lo = is_div ? quot : prod[31:0];

    assign stall_req = ((state == IDLE) & start & ~flush & ~rst) | (state == BUSY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 5'd0;
            is_div   <= 1'b0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            addend   <= 32'd0;
            acc      <= 64'd0;
            hi       <= 32'd0;
            lo       <= 32'd0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !flush) begin
                        if (div_by_zero) begin
                            hi    <= operand_1;
                            lo    <= 32'hFFFF_FFFF;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            is_div   <= op_div;
                            neg_main <= a_neg ^ b_neg;
                            neg_rem  <= a_neg;
                            addend   <= op_div ? b_mag : a_mag;
                            acc      <= {32'd0, op_div ? a_mag : b_mag};
                            cnt      <= 5'd0;
                            state    <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        acc <= acc_next;
                        cnt <= cnt + 5'd1;
                        if (cnt == 5'd31) begin
                            hi    <= res_hi;
                            lo    <= res_lo;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit: results, latency, stall, flush and reset abort.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand_1;
    logic [31:0] operand_2;
    logic        flush;
    logic        stall_req;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    mult_div_unit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .operand_1 (operand_1),
        .operand_2 (operand_2),
        .flush     (flush),
        .stall_req (stall_req),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge in IDLE; returns at a negedge back in IDLE.
    // With hold set, start stays high through BUSY and DONE to show it is ignored there.
    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int exp_lat, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo, input bit hold);
        int lat;
        op = o; operand_1 = a; operand_2 = b; start = 1'b1;
        #1;
        check({tag, " stall_start"}, 64'(stall_req), 64'd1);
        @(negedge clk);
        if (!hold) start = 1'b0;
        operand_1 = 32'h5A5A_5A5A;
        operand_2 = 32'h0000_0003;
        op = ~o;
        lat = 1;
        while (!done && lat < 40) begin
            check({tag, " stall_busy"}, 64'(stall_req), 64'd1);
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " done"}, 64'(done), 64'd1);
        check({tag, " hi"}, 64'(hi), 64'(exp_hi));
        check({tag, " lo"}, 64'(lo), 64'(exp_lo));
        check({tag, " stall_done"}, 64'(stall_req), 64'd0);
        start = 1'b0;
        @(negedge clk);
        check({tag, " done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation ran past time limit");
        $fatal(1, "timeout");
    end

    initial begin
        bit seen;
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00;
        operand_1 = 32'd0; operand_2 = 32'd0;
        #1;
        check("rst hi", 64'(hi), 64'd0);
        check("rst lo", 64'(lo), 64'd0);
        check("rst done", 64'(done), 64'd0);
        start = 1'b1;
        #1;
        check("rst stall", 64'(stall_req), 64'd0);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        do_op("mult_neg3x7",   OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 33, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        do_op("multu_max",     OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        do_op("mult_minmin",   OP_MULT,  32'h8000_0000, 32'h8000_0000, 33, 32'h4000_0000, 32'h0000_0000, 1'b1);
        do_op("div_neg7by2",   OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        do_op("div_7byneg2",   OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 33, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
        do_op("divu_100by7",   OP_DIVU,  32'd100,       32'd7,         33, 32'h0000_0002, 32'h0000_000E, 1'b1);
        do_op("div_ovf",       OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0000_0000, 32'h8000_0000, 1'b0);
        do_op("divu_by0",      OP_DIVU,  32'h1234_5678, 32'h0000_0000,  1, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0);
        do_op("div_by0_hold",  OP_DIV,   32'hFFFF_FFFB, 32'h0000_0000,  1, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);
        do_op("divu_5by2",     OP_DIVU,  32'd5,         32'd2,         33, 32'h0000_0001, 32'h0000_0002, 1'b0);

        // Flush in BUSY cycle N+10 of a MULT.
        op = OP_MULT; operand_1 = 32'hFFFF_FFFD; operand_2 = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush stall", 64'(stall_req), 64'd0);
        check("flush done", 64'(done), 64'd0);
        check("flush hi", 64'(hi), 64'd1);
        check("flush lo", 64'(lo), 64'd2);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("flush no_done", 64'(seen), 64'd0);
        check("flush hi_hold", 64'(hi), 64'd1);

        // Reset at cycle N+5 of a DIVU.
        op = OP_DIVU; operand_1 = 32'd100; operand_2 = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst hi", 64'(hi), 64'd0);
        check("midrst lo", 64'(lo), 64'd0);
        check("midrst stall", 64'(stall_req), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("midrst no_done", 64'(seen), 64'd0);
        do_op("multu_2x3", OP_MULTU, 32'd2, 32'd3, 33, 32'h0000_0000, 32'h0000_0006, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
